// File: rtl/imem_responder_if.sv
// Fetch-side bundle for imem_responder: request, response and program-load channels.
// Latency: none (wiring only).
// Backpressure: valid/ready on request and response; the load port has no flow control.
interface imem_responder_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_addr;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_instr;
  logic [WIDTH-1:0] resp_addr;
  logic             resp_misaligned;
  logic             load_en;
  logic [WIDTH-1:0] load_addr;
  logic [7:0]       load_data;

  // Fetch logic / program loader side
  modport master (
    output req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
    input  req_ready, resp_valid, resp_instr, resp_addr, resp_misaligned
  );

  // Responder side
  modport slave (
    input  req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
    output req_ready, resp_valid, resp_instr, resp_addr, resp_misaligned
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: returns little-endian 32-bit words for PC fetch requests.
// Latency: LATENCY cycles from request acceptance to earliest response.
// Backpressure: req_ready drops at LATENCY+1 outstanding fetches; responses wait in a skid FIFO.
module imem_responder #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  imem_responder_if.slave bus
);

  localparam int DEPTH = LATENCY + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = $clog2(LATENCY + 2);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]      instr;
    logic [WIDTH-1:0] addr;
    logic             mis;
  } resp_t;

  logic [7:0]       mem_q [2**WIDTH];
  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] base;
  resp_t            fetch_dat;
  logic             push;
  resp_t            push_dat;

  resp_t            fifo_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fifo_empty;
  logic             fifo_full;
  logic [OW-1:0]    occ_q, occ_d;

  // Ready depends only on the outstanding count, so it never waits on req_valid or resp_ready
  assign bus.req_ready = (occ_q < OW'(LATENCY + 1));
  assign accept        = bus.req_valid && bus.req_ready;
  assign deliver       = bus.resp_valid && bus.resp_ready;
  assign base          = bus.req_addr & ~WIDTH'(3);

  // Program-image load port; memory is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
  end

  // Word read before this edge's load lands, so a same-edge load returns old data
  always_comb begin
    fetch_dat       = '0;
    fetch_dat.addr  = bus.req_addr;
    fetch_dat.mis   = |bus.req_addr[1:0];
    if (fetch_dat.mis) begin
      fetch_dat.instr = NOP;
    end else begin
      fetch_dat.instr = {mem_q[base | WIDTH'(3)], mem_q[base | WIDTH'(2)],
                         mem_q[base | WIDTH'(1)], mem_q[base]};
    end
  end

  // Read pipeline: the FIFO write is the final stage, so LATENCY-1 register stages precede it
  if (LATENCY == 1) begin : g_direct
    assign push     = accept;
    assign push_dat = fetch_dat;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    resp_t              dat_q [LATENCY-1];

    // Stages shift every cycle; only the valids matter after reset
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        for (int i = 0; i < LATENCY - 1; i++) begin
          dat_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= accept;
        dat_q[0] <= accept ? fetch_dat : '0;
        for (int i = 1; i < LATENCY - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign push     = vld_q[LATENCY-2];
    assign push_dat = dat_q[LATENCY-2];
  end

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(DEPTH));

  // FIFO pointer, count and outstanding-counter next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    occ_d    = occ_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (deliver) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, deliver})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({accept, deliver})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state; reset discards everything in flight and buffered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
    end
  end

  // FIFO storage; pointers alone decide which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_dat;
    end
  end

  // Head of FIFO drives the response; outputs are zeroed while idle
  always_comb begin
    bus.resp_valid      = !fifo_empty;
    bus.resp_instr      = '0;
    bus.resp_addr       = '0;
    bus.resp_misaligned = 1'b0;
    if (!fifo_empty) begin
      bus.resp_instr      = fifo_q[rd_ptr_q].instr;
      bus.resp_addr       = fifo_q[rd_ptr_q].addr;
      bus.resp_misaligned = fifo_q[rd_ptr_q].mis;
    end
  end

  // The outstanding limit must keep the FIFO from ever overflowing
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that answers program-counter fetch requests. Accepts a byte address over a valid/ready request channel, reads a little-endian 32-bit instruction from an internal byte-addressed memory through a fixed-latency read pipeline, and returns it over a valid/ready response channel with a skid buffer. Sits between the PC/fetch logic and the decode stage. A byte-wide load port preloads program images.

## Interface
- `WIDTH`, default 8: address width in bits. Memory holds 2**WIDTH bytes; 2**WIDTH must be at least 4.
- `LATENCY`, default 2: cycles from request acceptance to earliest response. Legal range is 1–4.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, 1: fetch request present.
- `req_ready`, output, 1: responder can accept a request this cycle.
- `req_addr`, input, WIDTH: byte address of the instruction (PC value).
- `resp_valid`, output, 1: response present.
- `resp_ready`, input, 1: consumer accepts the response.
- `resp_instr`, output, 32: instruction word.
- `resp_addr`, output, WIDTH: the request address this response answers.
- `resp_misaligned`, output, 1: request address had `[1:0]` ≠ 0.
- `load_en`, input, 1: write one memory byte.
- `load_addr`, input, WIDTH: byte address to write.
- `load_data`, input, 8: byte value to write.

## Operation
- **Acceptance:** a request is accepted on a rising edge where `req_valid && req_ready`.
- **Read data:** on acceptance, memory is read as it stands before that edge. The instruction word is `{mem[a+3], mem[a+2], mem[a+1], mem[a]}` with `a = {req_addr[WIDTH-1:2], 2'b00}`.
- **Misaligned requests:** if `req_addr[1:0]` ≠ 0, the response has `resp_misaligned=1` and `resp_instr=32'h00000013` (NOP). Memory is not used for that response.
- **Read pipeline:** LATENCY stages of {valid, instr, addr, misaligned}, advancing every cycle unconditionally. The last stage writes into a response FIFO of depth LATENCY+1.
- **Response output:** the FIFO head drives the `resp_*` outputs. The entry pops on an edge where `resp_valid && resp_ready`.
- **Outstanding counter:** `occ` has width ⌈log2(LATENCY+2)⌉. It counts accepted requests not yet delivered.
  - +1 on acceptance, −1 on delivery, unchanged when both occur on the same edge.
  - `req_ready = (occ < LATENCY+1)`, combinational from registered state only. It is independent of `req_valid` and `resp_ready`.
  - This guarantees the FIFO never overflows. A FIFO push with the FIFO full is an assertion failure.
- **Ordering:** responses leave in strict request order with no reordering. At most one request is accepted and at most one response delivered per cycle.
- **Idle outputs:** while `resp_valid=0`, `resp_instr`, `resp_addr` and `resp_misaligned` are driven 0.
- **Load port:** when `load_en=1`, `mem[load_addr] <= load_data` on the edge. This is independent of request traffic. A load and a fetch of the same word on the same edge returns the old data.
- **Memory contents:** memory is not reset; contents are unknown until loaded.

## Timing
- **Reset (asynchronous):** `rst` clears pipeline valids, FIFO pointers and `occ`. While `rst` is high and immediately after, outputs are `req_ready=1`, `resp_valid=0`, `resp_instr=0`, `resp_addr=0`, `resp_misaligned=0`.
- **Reset mid-operation:** all in-flight and buffered responses are discarded and none is emitted afterward. Memory contents are preserved.
- **Latency:** a request accepted at edge t gives `resp_valid=1` in the cycle after edge t+LATENCY−1, i.e. LATENCY cycles later, provided no older responses are pending.
- **Throughput:** with `resp_ready` held high, one request is accepted and one response delivered every cycle. `occ` settles at LATENCY and `req_ready` stays 1.
- **Backpressure:** with `resp_ready=0`, the FIFO fills.
  - `req_ready` drops once `occ=LATENCY+1`, i.e. after exactly LATENCY+1 accepts.
  - It rises the cycle after the first delivery.
  - While stalled, `resp_*` is held stable.
- **Boundary cases:**
  - With FIFO empty and pipeline valid, the response appears the next cycle.
  - With `occ=LATENCY+1`, a delivery on an edge re-enables `req_ready` for the following cycle, not the same one.
  - The top aligned address 2**WIDTH−4 reads bytes 2**WIDTH−4 through 2**WIDTH−1 with no wrap.

## Test plan
- **Basic fetch:** load bytes 0x93,0x00,0x10,0x00 at address 0x10, with LATENCY=2. Request 0x10 at cycle 0 with `resp_ready=1`. Require `resp_valid` at cycle 2 with `resp_instr=0x00100093`, `resp_addr=0x10` and `resp_misaligned=0`.
- **Streaming:** load distinct words at 0x00–0x1C, then issue back-to-back requests 0x00,0x04,…,0x1C with `resp_ready=1`. Require `req_ready` constantly 1 and eight in-order responses on consecutive cycles starting at cycle 2.
- **Backpressure:** hold `resp_ready=0` and offer requests every cycle. Require exactly 3 accepts (LATENCY=2), then `req_ready=0`. Release `resp_ready` and require 3 in-order responses, with `req_ready=1` one cycle after the first delivery.
- **Misaligned:** request 0x06. Require `resp_misaligned=1`, `resp_instr=0x00000013` and `resp_addr=0x06` after LATENCY cycles.
- **Load/fetch collision:** in the same cycle, load byte 0xFF to 0x20 and request 0x20, where the old word is 0x11223344. Require the response to be 0x11223344. A repeat request then returns 0x112233FF.
- **Reset mid-operation:** assert `rst` asynchronously with 2 responses buffered. Require immediate `resp_valid=0` and `req_ready=1`, no stale responses afterward, and preloaded memory still readable.
